// File: rtl/regfile_arb_pkg.sv
// Shared constants for the register-file write-port arbiter: default sizes,
// requester slot assignments and the hard-wired zero register address.
package regfile_arb_pkg;

  localparam int DEF_N_REQ  = 3;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

  // Requester slot assignment on the writeback side
  localparam int REQ_ALU    = 0;
  localparam int REQ_LOAD   = 1;
  localparam int REQ_MULDIV = 2;

  // Writes to this register are architecturally discarded
  localparam int REG_ZERO   = 0;

  // Width of an index into n requesters (at least one bit)
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: scans the eligible vector starting at the
// pointer, wrapping modulo N_REQ, and returns the first eligible requester.
module rr_pick
  import regfile_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int PTR_W = ptr_width(DEF_N_REQ)
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any_grant
);

  // First eligible index at or after ptr wins; at most one bit of grant set
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!any_grant && eligible[idx]) begin
        any_grant      = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between N_REQ writeback
// requesters. Valid/ready handshake per requester, round-robin grant, and a
// one-entry registered output stage that drives the write port and doubles as
// the in-flight write visible to forwarding/hazard logic.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    arb_en,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_reg,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    regWrite,
  output logic [ADDR_W-1:0]       write_reg,
  output logic [DATA_W-1:0]       write_data,
  output logic [N_REQ-1:0]        last_grant
);

  localparam int PTR_W = ptr_width(N_REQ);

  logic [N_REQ-1:0]  zero_req;
  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  pick_grant;
  logic [PTR_W-1:0]  pick_idx;
  logic              any_grant;
  logic [PTR_W-1:0]  rr_ptr;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;

  logic              wr_en_p1;
  logic [ADDR_W-1:0] wr_reg_p1;
  logic [DATA_W-1:0] wr_data_p1;
  logic [N_REQ-1:0]  grant_p1;

  // Split requests into zero-register discards and arbitration candidates
  always_comb begin
    zero_req = '0;
    eligible = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_valid[i]) begin
        if (req_reg[i*ADDR_W +: ADDR_W] == ADDR_W'(REG_ZERO)) begin
          zero_req[i] = 1'b1;
        end else begin
          eligible[i] = arb_en;
        end
      end
    end
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .eligible  (eligible),
    .ptr       (rr_ptr),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any_grant (any_grant)
  );

  // Winner's payload; zero-register discards are acked without touching state
  always_comb begin
    sel_reg   = req_reg[int'(pick_idx)*ADDR_W +: ADDR_W];
    sel_data  = req_data[int'(pick_idx)*DATA_W +: DATA_W];
    req_ready = rst_n ? (zero_req | pick_grant) : '0;
  end

  // ---- stage p0 -> p1: accept winner into the output stage, advance pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      wr_en_p1   <= 1'b0;
      grant_p1   <= '0;
      wr_reg_p1  <= '0;
      wr_data_p1 <= '0;
    end else begin
      wr_en_p1 <= any_grant;
      grant_p1 <= any_grant ? pick_grant : '0;
      if (any_grant) begin
        wr_reg_p1  <= sel_reg;
        wr_data_p1 <= sel_data;
        rr_ptr     <= (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
      end
    end
  end

  assign regWrite   = wr_en_p1;
  assign write_reg  = wr_reg_p1;
  assign write_data = wr_data_p1;
  assign last_grant = grant_p1;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: a reference round-robin model
// predicts req_ready each cycle and queues the expected write, which is popped
// and compared when the output stage presents it.
module tb_regfile_write_arbiter;
  import regfile_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            arb_en;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_reg;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            regWrite;
  logic [AW-1:0]   write_reg;
  logic [DW-1:0]   write_data;
  logic [N-1:0]    last_grant;

  typedef struct packed {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
    logic [N-1:0]  g;
  } wr_t;

  wr_t sb[$];
  int  mptr;
  int  n_checks;
  int  n_fail;

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .N_REQ  (N),
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arb_en     (arb_en),
    .req_valid  (req_valid),
    .req_reg    (req_reg),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .regWrite   (regWrite),
    .write_reg  (write_reg),
    .write_data (write_data),
    .last_grant (last_grant)
  );

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d);
    req_valid[i]        = v;
    req_reg[i*AW +: AW] = r;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_reg   = '0;
    req_data  = '0;
  endtask

  // One cycle: predict ready/grant from the model, cross the edge, then pop
  // the scoreboard against the output stage.
  task automatic step(input string tag);
    logic [N-1:0] exp_ready;
    int           win;
    int           idx;
    wr_t          e;
    #1;
    exp_ready = '0;
    win       = -1;
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_reg[i*AW +: AW] == '0) exp_ready[i] = 1'b1;
    if (arb_en) begin
      for (int k = 0; k < N; k++) begin
        idx = (mptr + k) % N;
        if (win < 0 && req_valid[idx] && req_reg[idx*AW +: AW] != '0) win = idx;
      end
    end
    if (win >= 0) begin
      exp_ready[win] = 1'b1;
      e.r = req_reg[win*AW +: AW];
      e.d = req_data[win*DW +: DW];
      e.g = '0;
      e.g[win] = 1'b1;
      sb.push_back(e);
    end
    n_checks++;
    if (req_ready !== exp_ready) begin
      n_fail++;
      $display("FAIL %s ready: got %b want %b", tag, req_ready, exp_ready);
    end
    @(posedge clk);
    if (win >= 0) mptr = (win + 1) % N;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if (regWrite !== 1'b1 || write_reg !== e.r || write_data !== e.d || last_grant !== e.g) begin
        n_fail++;
        $display("FAIL %s write: got we=%b reg=%0d data=%h grant=%b want we=1 reg=%0d data=%h grant=%b",
                 tag, regWrite, write_reg, write_data, last_grant, e.r, e.d, e.g);
      end
    end else begin
      n_checks++;
      if (regWrite !== 1'b0 || last_grant !== '0) begin
        n_fail++;
        $display("FAIL %s idle: got we=%b grant=%b want we=0 grant=000", tag, regWrite, last_grant);
      end
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    arb_en = 1'b1;
    clear_reqs();
    sb.delete();
    mptr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    arb_en = 1'b1;
    clear_reqs();
    set_req(REQ_ALU, 1'b1, 5'd5, 32'h1234);
    #12;
    n_checks++;
    if (regWrite !== 1'b0 || write_reg !== '0 || write_data !== '0 || last_grant !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got we=%b reg=%0d data=%h grant=%b want all zero",
               regWrite, write_reg, write_data, last_grant);
    end
    n_checks++;
    if (req_ready !== '0) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 000", req_ready);
    end
    do_reset();
  endtask

  task automatic test_single();
    set_req(REQ_ALU, 1'b1, 5'd5, 32'hDEADBEEF);
    step("single");
    n_checks++;
    if (regWrite !== 1'b1 || write_reg !== 5'd5 || write_data !== 32'hDEADBEEF || last_grant !== 3'b001) begin
      n_fail++;
      $display("FAIL single_direct: got we=%b reg=%0d data=%h grant=%b want 1/5/deadbeef/001",
               regWrite, write_reg, write_data, last_grant);
    end
    clear_reqs();
    step("single_after");
    n_checks++;
    if (regWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drop: got we=%b want 0", regWrite);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 1), 32'hA0 + i);
    for (int c = 0; c < 6; c++) begin
      #1;
      n_checks++;
      if (req_ready !== (3'b001 << (c % 3))) begin
        n_fail++;
        $display("FAIL fair_ready[%0d]: got %b want %b", c, req_ready, 3'b001 << (c % 3));
      end
      step("fair");
      n_checks++;
      if (regWrite !== 1'b1 || write_reg !== AW'(c % 3 + 1)) begin
        n_fail++;
        $display("FAIL fair_reg[%0d]: got we=%b reg=%0d want we=1 reg=%0d", c, regWrite, write_reg, c % 3 + 1);
      end
    end
    clear_reqs();
    step("fair_drain");
  endtask

  task automatic test_zero_reg();
    set_req(REQ_LOAD, 1'b1, 5'd0, 32'h55);
    set_req(REQ_MULDIV, 1'b1, 5'd7, 32'h77);
    #1;
    n_checks++;
    if (req_ready !== 3'b110) begin
      n_fail++;
      $display("FAIL zero_ready: got %b want 110", req_ready);
    end
    step("zero");
    n_checks++;
    if (write_reg !== 5'd7 || write_data !== 32'h77) begin
      n_fail++;
      $display("FAIL zero_write: got reg=%0d data=%h want reg=7 data=77", write_reg, write_data);
    end
    clear_reqs();
    step("zero_idle");
  endtask

  task automatic test_same_dest();
    set_req(REQ_ALU, 1'b1, 5'd4, 32'h11);
    set_req(REQ_MULDIV, 1'b1, 5'd4, 32'h22);
    #1;
    n_checks++;
    if (req_ready !== 3'b001) begin
      n_fail++;
      $display("FAIL same_ready0: got %b want 001", req_ready);
    end
    step("same0");
    n_checks++;
    if (write_data !== 32'h11) begin
      n_fail++;
      $display("FAIL same_first: got %h want 11", write_data);
    end
    set_req(REQ_ALU, 1'b0, 5'd0, 32'h0);
    #1;
    n_checks++;
    if (req_ready !== 3'b100) begin
      n_fail++;
      $display("FAIL same_ready2: got %b want 100", req_ready);
    end
    step("same2");
    clear_reqs();
    step("same_idle");
    n_checks++;
    if (regWrite !== 1'b0 || write_reg !== 5'd4 || write_data !== 32'h22) begin
      n_fail++;
      $display("FAIL same_final: got we=%b reg=%0d data=%h want we=0 reg=4 data=22",
               regWrite, write_reg, write_data);
    end
  endtask

  task automatic test_arb_en();
    arb_en = 1'b0;
    set_req(REQ_LOAD, 1'b1, 5'd9, 32'h99);
    set_req(REQ_ALU, 1'b1, 5'd0, 32'h5);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (req_ready !== 3'b001) begin
        n_fail++;
        $display("FAIL arb_off_ready[%0d]: got %b want 001", c, req_ready);
      end
      step("arb_off");
      n_checks++;
      if (regWrite !== 1'b0) begin
        n_fail++;
        $display("FAIL arb_off_we[%0d]: got %b want 0", c, regWrite);
      end
    end
    set_req(REQ_ALU, 1'b0, 5'd0, 32'h0);
    arb_en = 1'b1;
    step("arb_on");
    n_checks++;
    if (regWrite !== 1'b1 || write_reg !== 5'd9 || last_grant !== 3'b010) begin
      n_fail++;
      $display("FAIL arb_on_write: got we=%b reg=%0d grant=%b want 1/9/010", regWrite, write_reg, last_grant);
    end
    clear_reqs();
    set_req(REQ_MULDIV, 1'b1, 5'd10, 32'hAA);
    step("arb_load");
    arb_en = 1'b0;
    set_req(REQ_MULDIV, 1'b0, 5'd0, 32'h0);
    set_req(REQ_ALU, 1'b1, 5'd11, 32'hBB);
    #1;
    n_checks++;
    if (regWrite !== 1'b1 || write_reg !== 5'd10 || write_data !== 32'hAA) begin
      n_fail++;
      $display("FAIL arb_fall_hold: got we=%b reg=%0d data=%h want 1/10/aa", regWrite, write_reg, write_data);
    end
    step("arb_fall");
    arb_en = 1'b1;
    clear_reqs();
  endtask

  task automatic test_reset_mid();
    set_req(REQ_LOAD, 1'b1, 5'd3, 32'h33);
    step("mid_load");
    clear_reqs();
    set_req(REQ_LOAD, 1'b1, 5'd3, 32'h44);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (regWrite !== 1'b0 || last_grant !== '0 || req_ready !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_clear: got we=%b grant=%b ready=%b want 0/000/000", regWrite, last_grant, req_ready);
    end
    sb.delete();
    mptr = 0;
    clear_reqs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 1), 32'hC0 + i);
    #1;
    n_checks++;
    if (req_ready !== 3'b001) begin
      n_fail++;
      $display("FAIL mid_reset_ptr: got %b want 001", req_ready);
    end
    step("mid_after");
    clear_reqs();
    step("mid_drain");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    mptr     = 0;
    test_reset();
    test_single();
    test_fairness();
    test_zero_reg();
    test_same_dest();
    test_arb_en();
    test_reset_mid();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d pending want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
